// File: rtl/leaf_dispatch_rr.sv
// leaf_dispatch_rr: FIFO-buffered dispatcher offering items to leaves in strict round-robin order.
module leaf_dispatch_rr #(
  parameter int DATA_W   = 16,
  parameter int NUM_LEAF = 5,
  parameter int DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic [NUM_LEAF-1:0]       out_valid,
  input  logic [NUM_LEAF-1:0]       out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [7:0]                out_tag,
  output logic [$clog2(DEPTH):0]    fifo_count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int PW = NUM_LEAF > 1 ? $clog2(NUM_LEAF) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [7:0]        tag_q, tag_d;
  logic              push, pop;

  // Readiness comes from occupancy alone, so a same-cycle pop never frees room for a push.
  always_comb begin
    in_ready   = rst_n && (count_q < CW'(DEPTH));
    push       = in_valid && in_ready;
    pop        = rst_n && (count_q != '0) && out_ready[rr_q];
    out_valid  = (rst_n && (count_q != '0)) ? NUM_LEAF'(1) << rr_q : '0;
    out_data   = mem_q[rd_ptr_q];
    out_tag    = tag_q;
    fifo_count = count_q;
    wr_ptr_d   = push ? ((wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d   = pop ? ((rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1)) : rd_ptr_q;
    rr_d       = pop ? ((rr_q == PW'(NUM_LEAF - 1)) ? '0 : rr_q + PW'(1)) : rr_q;
    tag_d      = tag_q + 8'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= '0;
      tag_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
      tag_q    <= tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end
endmodule

// File: tb/tb_leaf_dispatch_rr.sv
// tb_leaf_dispatch_rr: directed stimulus with a scoreboard queue of expected dispatches.
module tb_leaf_dispatch_rr;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [4:0]  out_valid;
  logic [4:0]  out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_tag;
  logic [2:0]  fifo_count;

  int          n_cmp = 0;
  int          n_err = 0;
  int          ndisp = 0;
  logic [15:0] q[$];
  int          leaf = 0;
  logic [7:0]  mtag = 8'd0;

  leaf_dispatch_rr #(.DATA_W(16), .NUM_LEAF(5), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model advanced on the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      q.delete();
      leaf = 0;
      mtag = 8'd0;
    end else begin
      logic do_pop, do_push;
      chk("in_ready", 32'(in_ready), 32'(q.size() < 4));
      chk("fifo_count", 32'(fifo_count), 32'(q.size()));
      chk("out_valid", 32'(out_valid), q.size() > 0 ? 32'(5'd1 << leaf) : 32'd0);
      if (q.size() > 0) begin
        chk("out_data", 32'(out_data), 32'(q[0]));
        chk("out_tag", 32'(out_tag), 32'(mtag));
      end
      do_pop  = q.size() > 0 && out_ready[leaf];
      do_push = in_valid && q.size() < 4;
      if (do_pop) begin
        void'(q.pop_front());
        leaf = (leaf + 1) % 5;
        mtag = mtag + 8'd1;
        ndisp++;
      end
      if (do_push) q.push_back(in_data);
    end
  end

  task automatic drive(input logic v, input logic [15:0] d, input logic [4:0] r, input int n);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 5'h00, 3);
    rst_n = 1'b1;
    // single item dispatched to leaf 0
    drive(1'b1, 16'h0011, 5'h1f, 1);
    drive(1'b0, 16'h0, 5'h1f, 3);
    // six items around the ring
    for (int i = 1; i <= 6; i++) drive(1'b1, 16'(i), 5'h1f, 1);
    drive(1'b0, 16'h0, 5'h1f, 4);
    // fill with all leaves stalled
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 5'h00, 1);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) drive(1'b1, 16'(i), 5'h00, 1);
    drive(1'b0, 16'h0, 5'h00, 3);
    // full FIFO: pop without push, then push
    drive(1'b1, 16'h00aa, 5'h01, 2);
    drive(1'b0, 16'h0, 5'h00, 1);
    // strict order: wrong leaf ready is ignored
    drive(1'b0, 16'h0, 5'h02, 1);
    drive(1'b0, 16'h0, 5'h08, 3);
    drive(1'b0, 16'h0, 5'h04, 1);
    drive(1'b0, 16'h0, 5'h00, 1);
    drive(1'b1, 16'h00bb, 5'h00, 1);
    drive(1'b0, 16'h0, 5'h00, 2);
    // reset mid-operation, then tag wrap
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 5'h00, 1);
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 5'h00, 1);
    base = ndisp;
    for (int i = 0; i < 257; i++) drive(1'b1, 16'(i + 100), 5'h1f, 1);
    drive(1'b0, 16'h0, 5'h1f, 4);
    chk("disp_257", 32'(ndisp - base), 32'd257);
    chk("tag_after_wrap", 32'(out_tag), 32'd1);
    chk("drained_count", 32'(fifo_count), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
